mayor_serial_n: RTL and testbench
=================================

MAYOR_SERIAL_N -- requirements
Module: mayor_serial_n

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal values are 2 or more.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request a comparison; sampled on rising clk edges.
REQ-005 signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare; latched with start.
REQ-006 a  input  WIDTH  first operand; latched with start.
REQ-007 b  input  WIDTH  second operand; latched with start.
REQ-008 busy  output  1  high while a comparison is in progress.
REQ-009 done  output  1  one-cycle pulse when a result becomes valid.
REQ-010 gt  output  1  result: a > b.
REQ-011 eq  output  1  result: a == b.
REQ-012 lt  output  1  result: a < b.
REQ-013 nbits  output  clog2(WIDTH+1)  number of bit positions examined for the last result (1..WIDTH).

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 at an edge SHALL latch a, b and signed_mode, set the bit index to WIDTH-1, clear nbits, and enter RUN.
REQ-016 Each RUN edge SHALL examine one bit pair at the index, MSB first, and increment nbits by 1.
REQ-017 Unsigned compare: on the first differing bit, the operand with the 1 SHALL be the greater one.
REQ-018 Signed compare, MSB only: if the sign bits differ, the operand with the 1 SHALL be the smaller one; lower bits SHALL be compared as unsigned.
REQ-019 When a differing bit is found, the block SHALL set exactly one of gt or lt and enter DONE at the same edge (early termination).
REQ-020 When bit 0 is examined and equal, the block SHALL set eq and enter DONE.
REQ-021 Otherwise RUN SHALL decrement the index and remain in RUN.
REQ-022 Latency: a first difference at bit i SHALL enter DONE WIDTH-i edges after the start edge; equal operands SHALL enter DONE after WIDTH edges.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-025 gt, eq, lt and nbits SHALL hold their values from DONE until the next accepted start; they SHALL all read 0 during RUN.
REQ-026 gt, eq and lt SHALL be one-hot whenever done=1.
REQ-027 start in RUN or DONE SHALL be ignored, with no queuing; changes to a, b or signed_mode after the start edge SHALL not affect the result.
REQ-028 start held high continuously SHALL begin a new comparison at the first IDLE edge after DONE.

Reset
REQ-029 rst=1 SHALL immediately force IDLE with busy, done, gt, eq, lt and nbits at 0, including in mid-RUN, where the partial result is discarded.
REQ-030 After rst deasserts, no comparison SHALL begin until start is sampled in IDLE.

Verification (WIDTH=8)
REQ-031 start with a=0x80, b=0x7F, signed_mode=0 -> done after 1 RUN edge: gt=1, nbits=1.
REQ-032 Same operands with signed_mode=1 -> lt=1, nbits=1.
REQ-033 a=0x5A, b=0x5A -> done after 8 edges: eq=1, nbits=8; busy high for 9 cycles in total.
REQ-034 a=0x12, b=0x13, unsigned -> lt=1, nbits=8; a=0xF0, b=0xE0, signed -> gt=1, nbits=4.
REQ-035 start with a=0x01, b=0x00, pulse rst after 3 edges -> all outputs 0 and IDLE; a new start then yields gt=1, nbits=8.
REQ-036 A second start, with different operands, during RUN -> ignored; the first result is unchanged and only one done pulse occurs.

Source files
------------

// File: rtl/mayor_serial_n.sv
// Bit-serial magnitude comparator: it scans from the MSB down and stops at the first differing bit.
// It supports unsigned or two's-complement compare, and reports how many bit positions it examined.
module mayor_serial_n #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       gt,
  output logic                       eq,
  output logic                       lt,
  output logic [$clog2(WIDTH+1)-1:0] nbits
);

  localparam int IW = $clog2(WIDTH);
  localparam int NW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic [IW-1:0]    idx;
  logic [NW-1:0]    cnt;

  logic a_bit, b_bit, differ, msb, last, a_wins;

  always_comb begin
    state_next = state;
    a_bit      = a_q[idx];
    b_bit      = b_q[idx];
    differ     = a_bit ^ b_bit;
    msb        = (idx == IW'(WIDTH-1));
    last       = (idx == '0);
    // A set sign bit marks the smaller operand in two's complement.
    a_wins     = (signed_q && msb) ? b_bit : a_bit;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (differ || last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      nbits    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx      <= IW'(WIDTH-1);
            cnt      <= '0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
            nbits    <= '0;
          end
        end
        RUN: begin
          cnt <= cnt + NW'(1);
          if (differ) begin
            gt    <= a_wins;
            lt    <= ~a_wins;
            nbits <= cnt + NW'(1);
          end else if (last) begin
            eq    <= 1'b1;
            nbits <= cnt + NW'(1);
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mayor_serial_n.sv
// Directed self-checking bench for mayor_serial_n at WIDTH=8.
module tb_mayor_serial_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] a, b;
  logic       busy, done, gt, eq, lt;
  logic [3:0] nbits;

  int checks = 0;
  int errors = 0;

  mayor_serial_n #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done),
    .gt(gt), .eq(eq), .lt(lt), .nbits(nbits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one comparison and checks latency, busy span, result and hold behaviour.
  task automatic cmp(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic s,
                     input logic [2:0] exp_res, input logic [3:0] exp_n, input int exp_lat);
    int lat;
    int busy_n;
    @(negedge clk);
    a = av; b = bv; signed_mode = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; signed_mode = ~s;
    check({tag, " run_busy"}, busy, 1);
    check({tag, " run_outs"}, {done, gt, eq, lt, nbits}, 0);
    lat = 0;
    busy_n = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_span"}, busy_n, exp_lat + 1);
    check({tag, " result"}, {gt, eq, lt}, exp_res);
    check({tag, " nbits"}, nbits, exp_n);
    @(posedge clk); #1;
    check({tag, " idle"}, {busy, done}, 0);
    check({tag, " hold"}, {gt, eq, lt, nbits}, {exp_res, exp_n});
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #12;
    check("reset_outs", {busy, done, gt, eq, lt, nbits}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("no_spurious_start", busy, 0);

    // {gt,eq,lt}: 100 = gt, 010 = eq, 001 = lt
    cmp("u80_7f", 8'h80, 8'h7F, 1'b0, 3'b100, 4'd1, 1);
    cmp("s80_7f", 8'h80, 8'h7F, 1'b1, 3'b001, 4'd1, 1);
    cmp("eq5a",   8'h5A, 8'h5A, 1'b0, 3'b010, 4'd8, 8);
    cmp("u12_13", 8'h12, 8'h13, 1'b0, 3'b001, 4'd8, 8);
    cmp("sf0_e0", 8'hF0, 8'hE0, 1'b1, 3'b100, 4'd4, 4);
    cmp("s7f_80", 8'h7F, 8'h80, 1'b1, 3'b100, 4'd1, 1);
    cmp("sff_fe", 8'hFF, 8'hFE, 1'b1, 3'b100, 4'd8, 8);
    cmp("seq_ff", 8'hFF, 8'hFF, 1'b1, 3'b010, 4'd8, 8);

    // Reset in mid-RUN discards the partial result.
    @(negedge clk);
    a = 8'h01; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midrun_reset", {busy, done, gt, eq, lt, nbits}, 0);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("post_reset_idle", {busy, done}, 0);
    cmp("after_rst", 8'h01, 8'h00, 1'b0, 3'b100, 4'd8, 8);

    // A start during RUN is ignored and produces no extra done.
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'hF0; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignored_start_dones", dones, 1);
    check("ignored_start_res", {gt, eq, lt, nbits}, {3'b001, 4'd8});

    // Start held high restarts at the first IDLE edge after DONE.
    @(negedge clk);
    a = 8'h80; b = 8'h7F; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 check("held_done", {done, gt}, 2'b11);
    @(posedge clk); #1 check("held_idle", busy, 0);
    @(posedge clk); #1 check("held_restart", {busy, gt}, 2'b10);
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
